// File: rtl/regfile_wb.sv
// Register file with a one-entry write-back stage. Pending writes are forwarded to
// both operand read ports. The debug read port and the LED tap see only the array.
module regfile_wb #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31,
    parameter int LED_REG  = 6,
    parameter int LED_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ir_data,
    input  logic [DATA_W-1:0] dr_data,
    input  logic [DATA_W-1:0] c_data,
    input  logic [DATA_W-1:0] pc4_data,
    input  logic              memtoreg,
    input  logic              regdst,
    input  logic              link,
    input  logic              write_reg,
    input  logic [REG_AW-1:0] dbg_sel,
    output logic [DATA_W-1:0] rdata_A,
    output logic [DATA_W-1:0] rdata_B,
    output logic [DATA_W-1:0] rdata_show,
    output logic [LED_W-1:0]  led_out,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_num
);

    localparam int                NREG     = 2 ** REG_AW;
    localparam logic [REG_AW-1:0] LINK_IDX = REG_AW'(LINK_REG);
    localparam logic [REG_AW-1:0] LED_IDX  = REG_AW'(LED_REG);

    logic [DATA_W-1:0] r_regs [NREG];
    logic              r_wb_valid;
    logic [REG_AW-1:0] r_wb_num;
    logic [DATA_W-1:0] r_wb_data;

    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic [REG_AW-1:0] w_rd;
    logic [REG_AW-1:0] w_dest;
    logic [DATA_W-1:0] w_wdata;
    logic              w_unused_ir;

    assign w_rs        = REG_AW'(ir_data[25:21]);
    assign w_rt        = REG_AW'(ir_data[20:16]);
    assign w_rd        = REG_AW'(ir_data[15:11]);
    assign w_unused_ir = ^{ir_data[31:26], ir_data[10:0]};

    // Link overrides both the destination and the data source.
    always_comb begin
        w_dest  = regdst ? w_rd : w_rt;
        w_wdata = memtoreg ? dr_data : c_data;
        if (link) begin
            w_dest  = LINK_IDX;
            w_wdata = pc4_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_num   <= '0;
            r_wb_data  <= '0;
        end else if (write_reg && (w_dest != '0)) begin
            r_wb_valid <= 1'b1;
            r_wb_num   <= w_dest;
            r_wb_data  <= w_wdata;
        end else begin
            r_wb_valid <= 1'b0;
        end
    end

    // Entry 0 is only ever loaded by reset, so it stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_wb_valid && (r_wb_num != '0)) begin
            r_regs[r_wb_num] <= r_wb_data;
        end
    end

    always_comb begin
        rdata_A = r_regs[w_rs];
        if (w_rs == '0) begin
            rdata_A = '0;
        end else if (r_wb_valid && (r_wb_num == w_rs)) begin
            rdata_A = r_wb_data;
        end
    end

    always_comb begin
        rdata_B = r_regs[w_rt];
        if (w_rt == '0) begin
            rdata_B = '0;
        end else if (r_wb_valid && (r_wb_num == w_rt)) begin
            rdata_B = r_wb_data;
        end
    end

    assign rdata_show = r_regs[dbg_sel];
    assign led_out    = r_regs[LED_IDX][LED_W-1:0];
    assign wb_valid   = r_wb_valid;
    assign wb_num     = r_wb_num;

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Parametrised register-file block with an integrated write-back stage for the multicycle/pipelined CPU datapath.
- Decodes source and destination fields from the instruction word and selects write-back data from ALU, memory or link (PC+4).
- Holds the pending write for one cycle in a WB register. Forwards that pending value to both read ports.
- Exposes a debug read port and an LED tap register for the board display.

Parameters:
DATA_W, 32, register and datapath width
REG_AW, 5, register address width (2**REG_AW registers; register 0 hardwired to zero)
LINK_REG, 31, destination index used when link is asserted
LED_REG, 6, register index driven onto led_out
LED_W, 8, width of led_out (LED_W <= DATA_W)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
ir_data  in  32  instruction word; rs=[25:21], rt=[20:16], rd=[15:11], each truncated/zero-extended to REG_AW
dr_data  in  DATA_W  memory data register (load result)
c_data  in  DATA_W  ALU result register
pc4_data  in  DATA_W  return address for link writes
memtoreg  in  1  1: write data = dr_data, 0: c_data
regdst  in  1  1: destination rd, 0: rt
link  in  1  1: destination LINK_REG, data pc4_data (overrides regdst/memtoreg)
write_reg  in  1  write request this cycle
dbg_sel  in  REG_AW  debug read index
rdata_A  out  DATA_W  read port A (index rs), forwarded
rdata_B  out  DATA_W  read port B (index rt), forwarded
rdata_show  out  DATA_W  debug read of array[dbg_sel], not forwarded
led_out  out  LED_W  array[LED_REG][LED_W-1:0]
wb_valid  out  1  WB stage holds a pending write
wb_num  out  REG_AW  pending write index

Behaviour:
- Reset (async, rst=1): all array entries 0; wb_valid=0, wb_num=0, internal wb_data=0. Outputs are therefore rdata_A=rdata_B=rdata_show=0 and led_out=0 while reset is held. A pending write at reset assertion is discarded, never committed.
- Destination select, priority order: link → LINK_REG; else regdst → rd; else rt.
- Data select: link → pc4_data; else memtoreg → dr_data; else c_data.
- Edge N with write_reg=1 and destination != 0:
  - wb_valid<=1, wb_num<=dest, wb_data<=data.
  - Otherwise wb_valid<=0; wb_num and wb_data hold.
- Commit: at each edge where wb_valid=1, array[wb_num]<=wb_data. The capture of a new request at the same edge is independent of the commit, so back-to-back writes, one per cycle, are sustained.
- Write latency:
  - Value is visible on rdata_A/B combinationally from the cycle after edge N (via forwarding).
  - Value is visible on rdata_show/led_out from the cycle after edge N+1 (array).
- Forwarding: rdata_A = 0 if rs==0; else wb_data if wb_valid && wb_num==rs; else array[rs]. rdata_B is identical with rt.
- Register 0: never written (array entry constant 0). A write to index 0 never sets wb_valid. Reads of index 0 return 0 on all ports.
- Same-index consecutive writes: the later write wins. Forwarding always reflects the newest pending value.
- led_out and rdata_show are combinational from the array only. They never reflect wb_data.
- No combinational path from write_reg, memtoreg, regdst or link to any output. Outputs depend only on ir_data, dbg_sel and state.

Test Plan:
- Reset, then write_reg=1, regdst=1, rd=5, c_data=0x1234_5678 for one cycle → wb_valid=1, wb_num=5 next cycle. rdata_A with rs=5 reads 0x12345678 the same cycle. rdata_show with dbg_sel=5 reads 0 that cycle and 0x12345678 one cycle later.
- link=1, regdst=1, memtoreg=1, pc4_data=0x0000_0040 → register 31 = 0x40, rd unchanged, dr_data ignored.
- Write 0xDEAD_BEEF to index 0 via rt=0 → wb_valid stays 0. rdata_B(rt=0)=0 and rdata_show(0)=0.
- Back-to-back writes R6=0xAA then R6=0x55 on consecutive cycles, with rs=6 → rdata_A shows 0xAA then 0x55. led_out ends at 0x55 two edges after the second write.
- Pending write of 0x77 to R3, then rst pulsed before the commit edge → R3 reads 0 after reset, wb_valid=0.
- Load path: memtoreg=1, regdst=0, rt=9, dr_data=0xCAFE_0001, c_data=0x1 → R9=0xCAFE0001.
